// File: rtl/vga_capture.sv
// Captures one VGA frame (or a continuous stream of frames) into a framebuffer write port.
// Video inputs are qualified by pix_en; sync/blank edges are detected between qualified samples.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        start,
    input  logic        cont,
    input  logic        abort,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        line_err,
    output logic        frame_err,
    output logic [9:0]  dbg_h,
    output logic [9:0]  dbg_v
);

    typedef enum logic [1:0] {IDLE, ARM, VSYNC, ACTIVE} state_t;

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    state_t      state;
    logic        hs_q, vs_q, blank_q, cont_q;
    logic [9:0]  h_cnt, v_cnt;
    logic        vs_fall, vs_rise, blank_fall, pix_vld, in_window;
    logic [9:0]  v_closed;
    logic        unused_hs;

    function automatic logic [9:0] sat_inc(input logic [9:0] x);
        return (x == 10'd1023) ? x : x + 10'd1;
    endfunction

    assign vs_fall    = pix_en & vs_q & ~vga_vs;
    assign vs_rise    = pix_en & ~vs_q & vga_vs;
    assign blank_fall = pix_en & blank_q & ~vga_blank_n;
    assign pix_vld    = pix_en & vga_blank_n;
    assign in_window  = ({1'b0, h_cnt} < H_LIM) && ({1'b0, v_cnt} < V_LIM);
    // A line closing on the same sample as vsync must count toward the frame check.
    assign v_closed   = blank_fall ? sat_inc(v_cnt) : v_cnt;

    // Horizontal sync is tracked but never moves the counters.
    assign unused_hs = hs_q;

    assign busy  = (state != IDLE);
    assign dbg_h = h_cnt;
    assign dbg_v = v_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_q   <= 1'b0;
            cont_q    <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (pix_en) begin
                hs_q    <= vga_hs;
                vs_q    <= vga_vs;
                blank_q <= vga_blank_n;
            end
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= ARM;
                            line_err  <= 1'b0;
                            frame_err <= 1'b0;
                            cont_q    <= cont;
                        end
                    end
                    ARM: begin
                        if (vs_fall) state <= VSYNC;
                    end
                    VSYNC: begin
                        if (vs_rise) begin
                            state <= ACTIVE;
                            h_cnt <= '0;
                            v_cnt <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (pix_vld) begin
                            if (in_window) begin
                                wr_en   <= 1'b1;
                                wr_addr <= {h_cnt, v_cnt[8:0]};
                                wr_data <= {vga_r, vga_g, vga_b};
                            end
                            h_cnt <= sat_inc(h_cnt);
                        end
                        if (blank_fall) begin
                            if ({1'b0, h_cnt} != H_LIM) line_err <= 1'b1;
                            v_cnt <= v_closed;
                            h_cnt <= '0;
                        end
                        if (vs_fall) begin
                            if ({1'b0, v_closed} != V_LIM) frame_err <= 1'b1;
                            done  <= 1'b1;
                            state <= cont_q ? VSYNC : IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pix_en  in  1  pixel strobe; inputs below sampled only when pix_en=1.
REQ-006 SHALL have port vga_hs  in  1  horizontal sync, active-low.
REQ-007 SHALL have port vga_vs  in  1  vertical sync, active-low.
REQ-008 SHALL have port vga_blank_n  in  1  1 = active video pixel.
REQ-009 SHALL have ports vga_r, vga_g, vga_b  in  8 each  pixel colour.
REQ-010 SHALL have port start  in  1  request capture, one-cycle pulse.
REQ-011 SHALL have port cont  in  1  continuous mode, sampled when start is accepted.
REQ-012 SHALL have port abort  in  1  synchronous abort.
REQ-013 SHALL have port wr_en  out  1  framebuffer write strobe.
REQ-014 SHALL have port wr_addr  out  19  {h_cnt[9:0], v_cnt[8:0]}.
REQ-015 SHALL have port wr_data  out  24  {r,g,b}.
REQ-016 SHALL have ports busy out 1, done out 1, line_err out 1, frame_err out 1.
REQ-017 SHALL have ports dbg_h out 10 and dbg_v out 10, mirroring h_cnt and v_cnt.

Function
REQ-018 SHALL keep registers hs_q, vs_q, blank_q, holding the previous pix_en-qualified samples; edges are detected only on pix_en cycles.
REQ-019 SHALL have states IDLE, ARM, VSYNC, ACTIVE; busy=1 in every state except IDLE.
REQ-020 SHALL move IDLE->ARM on start=1, clearing line_err and frame_err and latching cont; start outside IDLE SHALL be ignored.
REQ-021 SHALL move ARM->VSYNC on a vs falling edge (vs_q=1, vga_vs=0).
REQ-022 SHALL move VSYNC->ACTIVE on a vs rising edge and clear h_cnt and v_cnt to 0.
REQ-023 In ACTIVE, on a pix_en cycle with vga_blank_n=1, SHALL write iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, then increment h_cnt, saturating at 1023.
REQ-024 Writes SHALL be registered: wr_en/wr_addr/wr_data valid exactly 1 cycle after the sampled pixel; wr_en otherwise 0, addr/data hold last value.
REQ-025 In ACTIVE, on a blank_n falling edge, SHALL set line_err if h_cnt!=H_ACTIVE, increment v_cnt (saturating at 1023), and clear h_cnt.
REQ-026 In ACTIVE, on a vs falling edge, SHALL set frame_err if v_cnt!=V_ACTIVE, pulse done for 1 cycle, and go to IDLE, or to VSYNC if the latched cont=1.
REQ-027 If a blank_n falling edge and a vs falling edge coincide, the line-closure SHALL be applied first and the frame check SHALL use the incremented v_cnt.
REQ-028 hs edges SHALL not change counters; h_cnt resets only per REQ-022/REQ-025.
REQ-029 abort=1 SHALL force IDLE next cycle from any state with no done pulse, no write, and error flags retained; abort takes priority over start.
REQ-030 line_err and frame_err SHALL be sticky until the next accepted start or reset.

Reset
REQ-031 On rst=1, SHALL immediately set: state IDLE; busy, done, wr_en, line_err, frame_err = 0; wr_addr, wr_data, h_cnt, v_cnt, dbg_h, dbg_v = 0; hs_q=1; vs_q=1; blank_q=0; latched cont=0.
REQ-032 Reset asserted mid-frame SHALL discard the capture; after release the block SHALL wait in IDLE for start.

Verification (H_ACTIVE=4, V_ACTIVE=2, pix_en=1)
REQ-033 start; vs low 2 cycles, then high; 2 lines of 4 active pixels, rgb=line*16+col, 2 blank cycles each; then vs low -> 8 writes at addr {col,line}, data as sent, done pulse, line_err=0, frame_err=0, IDLE.
REQ-034 Same frame with line 1 having 3 pixels -> 7 writes, line_err=1, frame_err=0.
REQ-035 Frame with 3 lines of 4 pixels -> 8 writes only (line 2 suppressed), frame_err=1, dbg_v=3 at done.
REQ-036 cont=1 at start, two frames -> two done pulses, busy stays 1, 16 writes total; abort -> IDLE with no third done.
REQ-037 abort during line 0, pixel 2 -> no further writes, busy=0 next cycle, done never pulses.
REQ-038 rst pulse mid-line 1 -> all outputs 0 immediately; start after release captures the next full frame correctly.
